muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the core controller and the M-extension unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_index_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_index_out;
  logic            wb_en;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_index_in,
    input  busy, done, result, rd_index_out, wb_en
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_index_in,
    output busy, done, result, rd_index_out, wb_en
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle 33x33 multiplier for MUL* ops.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus_io
);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Request decode
  logic            is_div_in, a_signed, b_signed, a_neg, b_neg, neg_in;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    is_div_in = bus_io.funct3[2];
    a_signed  = is_div_in ? ~bus_io.funct3[0]
                          : (bus_io.funct3[1:0] == 2'b01) || (bus_io.funct3[1:0] == 2'b10);
    b_signed  = is_div_in ? ~bus_io.funct3[0] : (bus_io.funct3[1:0] == 2'b01);
    a_neg     = a_signed & bus_io.rs1_data[XLEN-1];
    b_neg     = b_signed & bus_io.rs2_data[XLEN-1];
    a_mag     = a_neg ? (~bus_io.rs1_data + 1'b1) : bus_io.rs1_data;
    b_mag     = b_neg ? (~bus_io.rs2_data + 1'b1) : bus_io.rs2_data;
    // Remainder follows the dividend; product and quotient follow the sign difference.
    neg_in    = (is_div_in && bus_io.funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div_in && (bus_io.rs2_data == '0);
    div_ovf   = is_div_in && !bus_io.funct3[0]
                && (bus_io.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                && (bus_io.rs2_data == '1);
    if (div_zero) begin
      special_res = bus_io.funct3[1] ? bus_io.rs1_data : '1;
    end else begin
      special_res = bus_io.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  localparam int unsigned PW = 2 * XLEN + 2;
  logic signed [XLEN:0] fast_a, fast_b;
  logic signed [PW-1:0] fast_p;
  logic [XLEN-1:0]      fast_res;

  always_comb begin
    fast_a   = {a_signed & bus_io.rs1_data[XLEN-1], bus_io.rs1_data};
    fast_b   = {b_signed & bus_io.rs2_data[XLEN-1], bus_io.rs2_data};
    fast_p   = PW'(fast_a) * PW'(fast_b);
    fast_res = (bus_io.funct3[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`endif

  // One iteration of either algorithm on the shared accumulator
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, step, mul_prod;
  logic [XLEN-1:0]   mul_res, div_sel, div_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    // Upper half is the partial remainder, lower half shifts the dividend out / quotient in.
    div_trial = {1'b0, acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {2'b00, opnd_q};
    div_next  = div_trial[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step      = op_q[2] ? div_next : mul_next;
    mul_prod  = neg_q ? (~step + 1'b1) : step;
    mul_res   = (op_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    div_sel   = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    div_res   = neg_q ? (~div_sel + 1'b1) : div_sel;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          op_d  = bus_io.funct3;
          rd_d  = bus_io.rd_index_in;
          neg_d = neg_in;
          cnt_d = '0;
          if (is_div_in) begin
            opnd_d = b_mag;
            acc_d  = {{XLEN{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{XLEN{1'b0}}, b_mag};
          end
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = StFin;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div_in) begin
            result_d = fast_res;
            state_d  = StFin;
          end
`endif
          else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          result_d = op_q[2] ? div_res : mul_res;
          state_d  = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    bus_io.busy         = (state_q != StIdle);
    bus_io.done         = (state_q == StFin);
    bus_io.result       = result_q;
    bus_io.rd_index_out = rd_q;
    bus_io.wb_en        = (state_q == StFin) && (rd_q != 5'd0);
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan vectors plus random ops against a model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic [2:0]  vf  [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] va  [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEC,
                            32'hFFFFFFEC, 32'd100, 32'd100, 32'h1234, 32'h1234,
                            32'h80000000, 32'h80000000};
  logic [31:0] vb  [12] = '{32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd3,
                            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] vex [12] = '{32'hFFFFFFD6, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFA,
                            32'hFFFFFFFE, 32'd14, 32'd2, 32'hFFFFFFFF, 32'h1234,
                            32'h80000000, 32'h0};

  // Architectural RV32M result computed with wide integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    r   = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (ovf) r = 32'h80000000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Edges from accept (inclusive) until the done cycle
  function automatic int exp_edges(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if (f[2] && !f[0] && (a == 32'h80000000) && (b == 32'hFFFFFFFF)) return 1;
    if (!f[2] && FastMul) return 1;
    return 33;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                       output logic wb, output int edges);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.funct3      = f;
    bus.rs1_data    = a;
    bus.rs2_data    = b;
    bus.rd_index_in = rd;
    edges = 0;
    while (edges < 100) begin
      @(posedge clk);
      edges++;
      #1 bus.start = 1'b0;
      @(negedge clk);
      if (bus.done) break;
    end
    res = bus.result;
    rdo = bus.rd_index_out;
    wb  = bus.wb_en;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++;
    if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b want 0", bus.wb_en); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.result !== 32'h0) begin
      errors++; $display("FAIL reset_result: got %h want 0", bus.result);
    end
    checks++;
    if (bus.rd_index_out !== 5'd0) begin
      errors++; $display("FAIL reset_rd: got %0d want 0", bus.rd_index_out);
    end
  endtask

  task automatic test_directed();
    logic [31:0] res; logic [4:0] rdo; logic wb; int edges; logic [4:0] rd;
    for (int i = 0; i < 12; i++) begin
      rd = 5'(i + 5);
      issue(vf[i], va[i], vb[i], rd, res, rdo, wb, edges);
      checks++;
      if (res !== vex[i]) begin
        errors++; $display("FAIL dir%0d_result: got %h want %h", i, res, vex[i]);
      end
      checks++;
      if (edges != exp_edges(vf[i], va[i], vb[i])) begin
        errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, edges,
                           exp_edges(vf[i], va[i], vb[i]));
      end
      checks++;
      if (rdo !== rd) begin errors++; $display("FAIL dir%0d_rd: got %0d want %0d", i, rdo, rd); end
      checks++;
      if (wb !== 1'b1) begin errors++; $display("FAIL dir%0d_wb_en: got %b want 1", i, wb); end
    end
  endtask

  task automatic test_rd_zero();
    logic [31:0] res; logic [4:0] rdo; logic wb; int edges;
    issue(3'd0, 32'd3, 32'd4, 5'd0, res, rdo, wb, edges);
    checks++;
    if (edges != exp_edges(3'd0, 32'd3, 32'd4)) begin
      errors++; $display("FAIL rd0_done: got %0d edges want %0d", edges, exp_edges(3'd0, 32'd3, 32'd4));
    end
    checks++;
    if (wb !== 1'b0) begin errors++; $display("FAIL rd0_wb_en: got %b want 0", wb); end
    checks++;
    if (res !== 32'd12) begin errors++; $display("FAIL rd0_result: got %h want c", res); end
  endtask

  task automatic test_busy_ignore();
    int extra; int waited;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7;
    bus.rd_index_in = 5'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", bus.busy); end
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd5; bus.rs2_data = 32'd5;
    bus.rd_index_in = 5'd9;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    waited = 0;
    while (!bus.done && waited < 60) begin @(negedge clk); waited++; end
    checks++;
    if (bus.result !== 32'd14 || bus.rd_index_out !== 5'd3) begin
      errors++; $display("FAIL ign_first_op: got %h rd %0d want 0000000e rd 3",
                         bus.result, bus.rd_index_out);
    end
    extra = 0;
    repeat (40) begin @(negedge clk); if (bus.done || bus.busy) extra++; end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL ign_no_queue: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [4:0] rdo; logic wb; int edges; int seen;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd9; bus.rs2_data = 32'd11;
    bus.rd_index_in = 5'd17;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wb_en !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: got busy %b done %b wb %b want 0 0 0",
                         bus.busy, bus.done, bus.wb_en);
    end
    checks++;
    if (bus.result !== 32'h0 || bus.rd_index_out !== 5'd0) begin
      errors++; $display("FAIL midrst_outputs: got %h rd %0d want 0 rd 0", bus.result, bus.rd_index_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.done) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_no_done: got %0d done cycles want 0", seen); end
    issue(3'd0, 32'd9, 32'd11, 5'd17, res, rdo, wb, edges);
    checks++;
    if (res !== 32'd99 || edges != exp_edges(3'd0, 32'd9, 32'd11)) begin
      errors++; $display("FAIL midrst_recover: got %h after %0d edges want 00000063 after %0d",
                         res, edges, exp_edges(3'd0, 32'd9, 32'd11));
    end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b, exp; logic [4:0] rdo, rd; logic wb; logic [2:0] f; int edges;
    for (int i = 0; i < 60; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      exp = ref_result(f, a, b);
      issue(f, a, b, rd, res, rdo, wb, edges);
      checks++;
      if (res !== exp) begin
        errors++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h: got %h want %h", i, f, a, b, res, exp);
      end
      checks++;
      if (edges != exp_edges(f, a, b)) begin
        errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, edges, exp_edges(f, a, b));
      end
      checks++;
      if (rdo !== rd || wb !== (rd != 5'd0)) begin
        errors++; $display("FAIL rnd%0d_wb: got rd %0d wb %b want rd %0d wb %b", i, rdo, wb, rd,
                           rd != 5'd0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic [4:0] rdo; logic wb; int edges;
    logic [2:0]  f [3] = '{3'd5, 3'd1, 3'd6};
    logic [31:0] a [3] = '{32'hDEADBEEF, 32'h80000000, 32'h80000000};
    logic [31:0] b [3] = '{32'd0, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      issue(f[i], a[i], b[i], 5'(i + 20), res, rdo, wb, edges);
      checks++;
      if (res !== ref_result(f[i], a[i], b[i]) || edges != exp_edges(f[i], a[i], b[i])) begin
        errors++; $display("FAIL b2b%0d: got %h after %0d edges want %h after %0d", i, res, edges,
                           ref_result(f[i], a[i], b[i]), exp_edges(f[i], a[i], b[i]));
      end
    end
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.funct3      = 3'd0;
    bus.rs1_data    = 32'd0;
    bus.rs2_data    = 32'd0;
    bus.rd_index_in = 5'd0;
    test_reset();
    test_directed();
    test_rd_zero();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
